// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller for the fetch/decode/execute core: arbitrates redirects
// against stall requests, drives PC / IF-ID / ID-EX controls and keeps event counters.
//
// state | meaning
// RUN   | normal issue; a redirect beats a stall request
// FLUSH | post-redirect bubbles, flush_cnt counts the remaining ones
// HOLD  | pipeline frozen while a multi-cycle resource holds it
module pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_in,
    input  logic [31:0] jump_addr_in,
    input  logic        hold_req_in,
    input  logic        cnt_clr,
    output logic        pc_jump_en,
    output logic [31:0] pc_jump_addr,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] flush_cnt, flush_cnt_nxt;
    logic       jump_c, pc_hold_c, ifid_hold_c, ifid_flush_c, idex_flush_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        jump_c        = 1'b0;
        pc_hold_c     = 1'b0;
        ifid_hold_c   = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        case (state)
            RUN: begin
                if (jump_en_in) begin
                    jump_c       = 1'b1;
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_INIT;
                    end
                end else if (hold_req_in) begin
                    pc_hold_c    = 1'b1;
                    ifid_hold_c  = 1'b1;
                    idex_flush_c = 1'b1;
                    state_nxt    = HOLD;
                end
            end
            FLUSH: begin
                // EX already holds a bubble, so a jump request here is stale
                ifid_flush_c  = 1'b1;
                idex_flush_c  = 1'b1;
                pc_hold_c     = hold_req_in;
                flush_cnt_nxt = flush_cnt - 4'd1;
                if (flush_cnt <= 4'd1) begin
                    state_nxt = hold_req_in ? HOLD : RUN;
                end
            end
            HOLD: begin
                if (hold_req_in) begin
                    pc_hold_c    = 1'b1;
                    ifid_hold_c  = 1'b1;
                    idex_flush_c = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Controls are masked during reset so nothing leaks out while rst_n is low.
    assign pc_jump_en   = rst_n & jump_c;
    assign pc_hold      = rst_n & pc_hold_c;
    assign ifid_hold    = rst_n & ifid_hold_c;
    assign ifid_flush   = rst_n & ifid_flush_c;
    assign idex_flush   = rst_n & idex_flush_c;
    assign pc_jump_addr = pc_jump_en ? jump_addr_in : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt <= 32'd0;
            stall_cnt    <= 32'd0;
        end else if (cnt_clr) begin
            redirect_cnt <= 32'd0;
            stall_cnt    <= 32'd0;
        end else begin
            if (pc_jump_en) redirect_cnt <= redirect_cnt + 32'd1;
            if (pc_hold)    stall_cnt    <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table through a scoreboard queue, plus hand-written
// sequences for flush length, hold/redirect overlap, reset abort and counter wrap/clear.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, jump_en_in, hold_req_in, cnt_clr;
    logic [31:0] jump_addr_in;

    logic        je1, ph1, ih1, iff1, idf1;
    logic [31:0] ja1, rc1, sc1;
    logic        je3, ph3, ih3, iff3, idf3;
    logic [31:0] ja3, rc3, sc3;

    logic [4:0]  ctl1, ctl3;
    assign ctl1 = {je1, ph1, ih1, iff1, idf1};
    assign ctl3 = {je3, ph3, ih3, iff3, idf3};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .jump_en_in(jump_en_in), .jump_addr_in(jump_addr_in),
        .hold_req_in(hold_req_in), .cnt_clr(cnt_clr),
        .pc_jump_en(je1), .pc_jump_addr(ja1), .pc_hold(ph1), .ifid_hold(ih1),
        .ifid_flush(iff1), .idex_flush(idf1), .redirect_cnt(rc1), .stall_cnt(sc1)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .jump_en_in(jump_en_in), .jump_addr_in(jump_addr_in),
        .hold_req_in(hold_req_in), .cnt_clr(cnt_clr),
        .pc_jump_en(je3), .pc_jump_addr(ja3), .pc_hold(ph3), .ifid_hold(ih3),
        .ifid_flush(iff3), .idex_flush(idf3), .redirect_cnt(rc3), .stall_cnt(sc3)
    );

    // ctl packing: {pc_jump_en, pc_hold, ifid_hold, ifid_flush, idex_flush}
    typedef struct {
        logic        jump;
        logic [31:0] addr;
        logic        hold;
        logic        clr;
        logic [4:0]  ctl;
        logic [31:0] jaddr;
        logic [31:0] rcnt;
        logic [31:0] scnt;
    } vec_t;

    vec_t vecs[14];
    vec_t exp_q[$];

    function automatic vec_t mk(logic j, logic [31:0] a, logic h, logic c,
                                logic [4:0] ctl, logic [31:0] ja, logic [31:0] r, logic [31:0] s);
        vec_t v;
        v.jump = j; v.addr = a; v.hold = h; v.clr = c;
        v.ctl = ctl; v.jaddr = ja; v.rcnt = r; v.scnt = s;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(string name, logic [4:0] act, logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: ctl got %b expected %b", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic j, logic [31:0] a, logic h, logic c);
        jump_en_in   = j;
        jump_addr_in = a;
        hold_req_in  = h;
        cnt_clr      = c;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t e;
        vecs[0]  = mk(0, 32'h0,   0, 0, 5'b00000, 32'h0,   0, 0);
        vecs[1]  = mk(1, 32'h40,  0, 0, 5'b10011, 32'h40,  0, 0);
        vecs[2]  = mk(0, 32'h0,   0, 0, 5'b00000, 32'h0,   1, 0);
        vecs[3]  = mk(0, 32'h0,   1, 0, 5'b01101, 32'h0,   1, 0);
        vecs[4]  = mk(0, 32'h0,   1, 0, 5'b01101, 32'h0,   1, 1);
        vecs[5]  = mk(1, 32'h44,  1, 0, 5'b01101, 32'h0,   1, 2);
        vecs[6]  = mk(0, 32'h0,   0, 0, 5'b00000, 32'h0,   1, 3);
        vecs[7]  = mk(1, 32'h80,  1, 0, 5'b10011, 32'h80,  1, 3);
        vecs[8]  = mk(0, 32'h0,   1, 0, 5'b01101, 32'h0,   2, 3);
        vecs[9]  = mk(0, 32'h0,   0, 0, 5'b00000, 32'h0,   2, 4);
        vecs[10] = mk(1, 32'h100, 0, 1, 5'b10011, 32'h100, 2, 4);
        vecs[11] = mk(0, 32'h0,   0, 0, 5'b00000, 32'h0,   0, 0);
        vecs[12] = mk(1, 32'hC,   0, 0, 5'b10011, 32'hC,   0, 0);
        vecs[13] = mk(0, 32'h0,   0, 0, 5'b00000, 32'h0,   1, 0);

        // reset with requests active: everything must read zero
        rst_n = 1'b0;
        drive(1, 32'hDEAD, 1, 0);
        #2;
        chk_ctl("reset_ctl1", ctl1, 5'b00000);
        chk_ctl("reset_ctl3", ctl3, 5'b00000);
        chk("reset_ja1", ja1, 32'h0);
        chk("reset_rc1", rc1, 32'h0);
        chk("reset_sc1", sc1, 32'h0);
        drive(0, 0, 0, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_ctl("idle_ctl1", ctl1, 5'b00000);
            chk("idle_rc1", rc1, 32'h0);
            chk("idle_sc1", sc1, 32'h0);
            next_cycle();
        end

        pulse_reset();
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].jump, vecs[i].addr, vecs[i].hold, vecs[i].clr);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            chk_ctl($sformatf("vec%0d_ctl", i), ctl1, e.ctl);
            chk($sformatf("vec%0d_jaddr", i), ja1, e.jaddr);
            chk($sformatf("vec%0d_rcnt", i), rc1, e.rcnt);
            chk($sformatf("vec%0d_scnt", i), sc1, e.scnt);
            next_cycle();
        end

        // asynchronous reset mid-activity
        drive(1, 32'h55, 1, 0);
        @(negedge clk);
        chk_ctl("prerst_ctl1", ctl1, 5'b10011);
        #1;
        rst_n = 1'b0;
        #1;
        chk_ctl("midrst_ctl1", ctl1, 5'b00000);
        chk_ctl("midrst_ctl3", ctl3, 5'b00000);
        chk("midrst_ja1", ja1, 32'h0);
        chk("midrst_rc1", rc1, 32'h0);
        chk("midrst_sc1", sc1, 32'h0);
        drive(0, 0, 0, 0);
        next_cycle();
        rst_n = 1'b1;

        // hold for 4 cycles
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0);
            @(negedge clk);
            chk_ctl($sformatf("hold4_c%0d", i), ctl1, 5'b01101);
            next_cycle();
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk_ctl("hold4_release", ctl1, 5'b00000);
        chk("hold4_scnt", sc1, 32'd4);
        next_cycle();
        drive(1, 32'h60, 0, 0);
        @(negedge clk);
        chk_ctl("hold4_back_run", ctl1, 5'b10011);
        next_cycle();

        // jump and hold rising together, FLUSH_CYCLES=1
        drive(0, 0, 0, 1);
        next_cycle();
        drive(1, 32'h200, 1, 0);
        @(negedge clk);
        chk_ctl("jh_c0", ctl1, 5'b10011);
        chk("jh_c0_addr", ja1, 32'h200);
        next_cycle();
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk_ctl("jh_c1", ctl1, 5'b01101);
        next_cycle();
        @(negedge clk);
        chk_ctl("jh_c2", ctl1, 5'b01101);
        next_cycle();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk_ctl("jh_c3", ctl1, 5'b00000);
        chk("jh_rcnt", rc1, 32'd1);
        chk("jh_scnt", sc1, 32'd2);
        next_cycle();

        // FLUSH_CYCLES=3: jump held high for three cycles
        pulse_reset();
        drive(1, 32'h300, 0, 0);
        @(negedge clk);
        chk_ctl("fl3_c0", ctl3, 5'b10011);
        chk("fl3_c0_addr", ja3, 32'h300);
        next_cycle();
        @(negedge clk);
        chk_ctl("fl3_c1", ctl3, 5'b00011);
        chk("fl3_c1_addr", ja3, 32'h0);
        next_cycle();
        @(negedge clk);
        chk_ctl("fl3_c2", ctl3, 5'b00011);
        next_cycle();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk_ctl("fl3_c3", ctl3, 5'b00000);
        chk("fl3_rcnt", rc3, 32'd1);
        next_cycle();

        // FLUSH_CYCLES=3: stall raised during the flush window
        drive(1, 32'h400, 0, 0);
        @(negedge clk);
        chk_ctl("flh_c0", ctl3, 5'b10011);
        next_cycle();
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk_ctl("flh_c1", ctl3, 5'b01011);
        next_cycle();
        @(negedge clk);
        chk_ctl("flh_c2", ctl3, 5'b01011);
        next_cycle();
        @(negedge clk);
        chk_ctl("flh_c3", ctl3, 5'b01101);
        next_cycle();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk_ctl("flh_c4", ctl3, 5'b00000);
        chk("flh_rcnt", rc3, 32'd2);
        chk("flh_scnt", sc3, 32'd3);
        next_cycle();

        // counter wrap, then clear overriding a redirect increment
        force dut1.stall_cnt = 32'hFFFFFFFF;
        #1;
        release dut1.stall_cnt;
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk_ctl("wrap_hold", ctl1, 5'b01101);
        next_cycle();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_scnt", sc1, 32'h0);
        next_cycle();
        drive(1, 32'h500, 0, 1);
        @(negedge clk);
        chk_ctl("clr_jump", ctl1, 5'b10011);
        next_cycle();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("clr_rcnt", rc1, 32'h0);
        chk("clr_scnt", sc1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline controller for the 3-stage core (fetch, decode, execute). It arbitrates between control-flow redirects raised by execution and stall requests from multi-cycle resources. From these it drives the PC register, IF/ID register and ID/EX register with redirect, hold and flush controls. It also keeps redirect and stall event counters for performance measurement.

## Interface
Parameters:
- FLUSH_CYCLES, 1: bubble cycles inserted after a redirect, including the redirect cycle. Legal range 1..15.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- jump_en_in  input  1  execution resolved a taken branch or jal this cycle.
- jump_addr_in  input  32  redirect target PC.
- hold_req_in  input  1  level stall request from a multi-cycle resource.
- cnt_clr  input  1  synchronous clear of both event counters.
- pc_jump_en  output  1  PC register loads pc_jump_addr next edge.
- pc_jump_addr  output  32  redirect target.
- pc_hold  output  1  PC register keeps its value.
- ifid_hold  output  1  IF/ID register keeps its value.
- ifid_flush  output  1  IF/ID loads NOP 32'h00000013.
- idex_flush  output  1  ID/EX loads a bubble (rd_wen=0, rd_addr=0, rs data 0).
- redirect_cnt  output  32  count of cycles with pc_jump_en=1.
- stall_cnt  output  32  count of cycles with pc_hold=1.

## Operation
- FSM states: RUN, FLUSH, HOLD. flush_cnt is 4 bits.
- Control outputs are combinational from state and inputs. pc_jump_addr = jump_addr_in whenever pc_jump_en=1, else 0.
- RUN, priority jump > hold > none:
  - jump_en_in=1: pc_jump_en=1, ifid_flush=1, idex_flush=1, pc_hold=0, ifid_hold=0. If FLUSH_CYCLES>1, next is FLUSH with flush_cnt=FLUSH_CYCLES-1; else stay in RUN.
  - hold_req_in=1 and jump_en_in=0: pc_hold=1, ifid_hold=1, idex_flush=1. Next is HOLD.
  - Neither asserted: all control outputs 0.
- FLUSH:
  - ifid_flush=1, idex_flush=1. jump_en_in is ignored because EX holds a bubble.
  - pc_hold=hold_req_in; ifid_hold=0.
  - flush_cnt decrements every cycle. When flush_cnt==1, next is RUN (HOLD if hold_req_in=1).
- HOLD:
  - While hold_req_in=1: pc_hold=1, ifid_hold=1, idex_flush=1. jump_en_in is ignored.
  - When hold_req_in=0: all control outputs 0 and next is RUN. Release costs no extra cycle.
- Counters:
  - redirect_cnt increments on each edge where pc_jump_en=1.
  - stall_cnt increments on each edge where pc_hold=1.
  - Both wrap modulo 2^32.
  - cnt_clr=1 zeroes both counters on the next edge and overrides any increment that cycle.
- ifid_hold and ifid_flush are never both 1.

## Timing
- Reset, asynchronous:
  - State goes to RUN, flush_cnt=0, redirect_cnt=0, stall_cnt=0.
  - While rst_n=0, all control outputs are forced to 0 regardless of inputs.
  - The first edge after deassertion evaluates normally from RUN.
- Reset mid-FLUSH or mid-HOLD aborts immediately; no pending redirect survives.
- Redirect latency is 0 cycles:
  - pc_jump_en is asserted in the same cycle as jump_en_in.
  - PC equals the target after the next edge.
  - The wrong-path fetch is squashed the same cycle.
- Bubble count per redirect is exactly FLUSH_CYCLES cycles of ifid_flush=1.
- Jump and hold asserted together in RUN: the redirect wins. hold_req_in is re-evaluated in the next state (FLUSH or RUN), so the stall starts the following cycle.
- A hold of N cycles gives exactly N cycles of pc_hold=1, unless it overlaps a redirect cycle.
- Counter outputs are registered and reflect events up to the previous edge.

## Test plan
- Reset then idle, FLUSH_CYCLES=1, 10 cycles with no requests: all control outputs 0, both counters 0. Asserting rst_n=0 mid-run zeroes outputs and counters immediately.
- Single jump, FLUSH_CYCLES=1, jump_addr_in=32'h00000040 for 1 cycle:
  - pc_jump_en=1 and pc_jump_addr=32'h40 that cycle, ifid_flush=idex_flush=1 for 1 cycle.
  - redirect_cnt=1 afterwards.
- FLUSH_CYCLES=3, jump, then jump_en_in held high for 2 more cycles: ifid_flush=1 for exactly 3 cycles; pc_jump_en=1 only in the first; redirect_cnt=1.
- hold_req_in high for 4 cycles then low:
  - pc_hold=ifid_hold=idex_flush=1 for exactly 4 cycles, all 0 in cycle 5.
  - stall_cnt=4; state returns to RUN.
- jump_en_in and hold_req_in rise together, hold kept high 3 cycles, FLUSH_CYCLES=1:
  - Cycle 0: redirect only, pc_hold=0.
  - Cycles 1-2: hold outputs.
  - Final counts: redirect_cnt=1, stall_cnt=2.
- Counter wrap and clear: force stall_cnt=32'hFFFFFFFF, hold 1 cycle, then stall_cnt=0. Assert cnt_clr together with a jump: redirect_cnt=0 after that edge.
